// File: rtl/aes_stream_gearbox_if.sv
// Minimal HWPE stream interface used on both 32-bit sides of the AES gearbox.
// Carries a valid/ready handshake with a data word and a byte strobe.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/aes_stream_gearbox.sv
// 32 <-> 128 bit gearbox between the HWPE streamer and the AES datapath.
// Optional feature macro: AES_GEARBOX_BYTESWAP_EN (byte-reverse every word on both sides).
module aes_stream_gearbox #(
    parameter int unsigned NB_WORDS = 4,
    parameter int unsigned WORD_W   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    hwpe_stream_intf_stream.sink         word_in,
    output logic [NB_WORDS*WORD_W-1:0]   blk_o,
    output logic                         blk_valid_o,
    input  logic                         blk_ready_i,
    input  logic [NB_WORDS*WORD_W-1:0]   res_i,
    input  logic                         res_valid_i,
    output logic                         res_ready_o,
    hwpe_stream_intf_stream.source       word_out,
    output logic [1:0]                   in_cnt_o,
    output logic [1:0]                   out_cnt_o,
    output logic                         busy_o
);

    typedef enum logic {FILL, FULL}  pack_state_e;
    typedef enum logic {IDLE, DRAIN} unpack_state_e;

    pack_state_e               pack_state;
    unpack_state_e             unpack_state;
    logic [1:0]                in_cnt;
    logic [1:0]                out_cnt;
    logic [NB_WORDS*WORD_W-1:0] blk_q;
    logic [NB_WORDS*WORD_W-1:0] res_q;

    // Byte order seen by the AES core (FIPS-197 big-endian when enabled).
    function automatic logic [WORD_W-1:0] map_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
`ifdef AES_GEARBOX_BYTESWAP_EN
        for (int b = 0; b < int'(WORD_W / 8); b++) begin
            r[8*b +: 8] = w[WORD_W-8-8*b +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    // Packer: collects four words, then holds the block until it is taken.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_state <= FILL;
            in_cnt     <= 2'd0;
            // NOTE: the block register is reset as well so blk_o reads 0 out of reset.
            blk_q      <= '0;
        end else if (clear_i) begin
            pack_state <= FILL;
            in_cnt     <= 2'd0;
        end else begin
            case (pack_state)
                FILL: if (word_in.valid) begin
                    blk_q[in_cnt*WORD_W +: WORD_W] <= map_word(word_in.data);
                    in_cnt <= in_cnt + 2'd1;
                    if (in_cnt == 2'd3) pack_state <= FULL;
                end
                FULL: if (blk_ready_i) pack_state <= FILL;
                default: pack_state <= FILL;
            endcase
        end
    end

    // Unpacker: registers one result and serialises it word by word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unpack_state <= IDLE;
            out_cnt      <= 2'd0;
            res_q        <= '0;
        end else if (clear_i) begin
            unpack_state <= IDLE;
            out_cnt      <= 2'd0;
        end else begin
            case (unpack_state)
                IDLE: if (res_valid_i) begin
                    res_q        <= res_i;
                    out_cnt      <= 2'd0;
                    unpack_state <= DRAIN;
                end
                DRAIN: if (word_out.ready) begin
                    out_cnt <= out_cnt + 2'd1;
                    if (out_cnt == 2'd3) unpack_state <= IDLE;
                end
                default: unpack_state <= IDLE;
            endcase
        end
    end

    // All handshake outputs decode state only, so no ready->valid combinational path exists.
    assign word_in.ready  = (pack_state == FILL);
    assign blk_valid_o    = (pack_state == FULL);
    assign blk_o          = blk_q;
    assign res_ready_o    = (unpack_state == IDLE);
    assign word_out.valid = (unpack_state == DRAIN);
    assign word_out.data  = map_word(res_q[out_cnt*WORD_W +: WORD_W]);
    assign word_out.strb  = '1;
    assign in_cnt_o       = in_cnt;
    assign out_cnt_o      = out_cnt;
    assign busy_o         = (pack_state != FILL) || (in_cnt != 2'd0) || (unpack_state != IDLE);

endmodule
